// File: rtl/sub_sequencer.sv
// sub_sequencer: wide subtractor built from one shared 5-bit full-subtractor slice.
// Operands of 5*NUM_SLICES bits are processed one slice per clock, LSB slice first,
// with the borrow carried between slices in a register.
// Optional feature macro: SUB_SEQ_SATURATE_EN clamps an underflowed result to zero
// (b_out still reports the underflow).

// 5-bit full subtractor: {bout, d} = x - y - bin
module FiveBitFullSubtractor (
    input  logic [4:0] x_i,
    input  logic [4:0] y_i,
    input  logic       bin_i,
    output logic [4:0] d_o,
    output logic       bout_o
);
    logic [5:0] wide;

    // Borrow-out is the sign bit of the 6-bit difference
    always_comb begin
        wide   = {1'b0, x_i} - {1'b0, y_i} - {5'd0, bin_i};
        d_o    = wide[4:0];
        bout_o = wide[5];
    end
endmodule

module sub_sequencer #(
    parameter int NUM_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [5*NUM_SLICES-1:0] a,
    input  logic [5*NUM_SLICES-1:0] b,
    input  logic                    b_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [5*NUM_SLICES-1:0] diff,
    output logic                    b_out,
    output logic                    busy
);
    localparam int W     = 5 * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [4:0]       a_sl [NUM_SLICES];
    logic [4:0]       b_sl [NUM_SLICES];
    logic [4:0]       a_slice, b_slice, slice_diff;
    logic             slice_bout;
    logic             accept, last_slice;

    // Per-slice views of the latched operands
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*5 +: 5];
            assign b_sl[gi] = b_q[gi*5 +: 5];
        end
    endgenerate

    assign accept     = (state_q == IDLE) && start_valid;
    assign last_slice = (idx_q == LAST_IDX);

    // Select the slice addressed by the current index
    always_comb begin
        a_slice = 5'd0;
        b_slice = 5'd0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_slice = a_sl[k];
                b_slice = b_sl[k];
            end
        end
    end

    FiveBitFullSubtractor u_slice (
        .x_i    (a_slice),
        .y_i    (b_slice),
        .bin_i  (borrow_q),
        .d_o    (slice_diff),
        .bout_o (slice_bout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; a request is only taken in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last_slice)  state_d = DONE;
            DONE:    if (res_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q == RUN) || (state_q == DONE);
        res_valid   = (state_q == DONE);
    end

    // Datapath next values: latch on accept, one slice per RUN cycle
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = b_in;
            idx_d    = '0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                if (idx_q == IDX_W'(k)) diff_d[k*5 +: 5] = slice_diff;
            end
            borrow_d = slice_bout;
            idx_d    = last_slice ? '0 : idx_q + IDX_W'(1);
`ifdef SUB_SEQ_SATURATE_EN
            // Floor clamp, applied on the same edge as the last slice
            if (last_slice && slice_bout) diff_d = '0;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
        end
    end

    assign diff  = diff_q;
    assign b_out = borrow_q;

endmodule
